// File: rtl/regfile_dumper.sv
// Debug readout engine: walks register-file indices FIRST_REG..LAST_REG over one read port
// and streams each word on a valid/ready link. Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat.
module regfile_dumper #(
  parameter int DW        = 64,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 30
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [4:0]    ra,
  input  logic [DW-1:0] rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [4:0]    out_idx,
  output logic          out_last,
  output logic          out_chk
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_READ = 3'd1, S_SEND = 3'd2, S_CHK = 3'd3, S_DONE = 3'd4
  } state_t;

  function automatic logic [DW-1:0] csum_fold(input logic [DW-1:0] acc, input logic [DW-1:0] beat);
    return acc ^ beat;
  endfunction

  logic [DW-1:0] csum_q, csum_d;
  logic          chk_q, chk_d;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_READ = 3'd1, S_SEND = 3'd2, S_DONE = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [4:0]    ra_q, ra_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [4:0]    idx_q, idx_d;
  logic          last_q, last_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_READ;
        else       state_d = S_IDLE;
      end
      S_READ: state_d = S_SEND;
      S_SEND: begin
        if (valid_q && out_ready) begin
          if (ra_q != LAST_IDX) begin
            state_d = S_READ;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end
        end else begin
          state_d = S_SEND;
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CHK: begin
        if (valid_q && out_ready) state_d = S_DONE;
        else                      state_d = S_CHK;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    ra_d    = ra_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d  = csum_q;
    chk_d   = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d   = FIRST_IDX;
          busy_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d = '0;
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      S_READ: begin
        data_d  = rd;
        idx_d   = ra_q;
        valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        last_d  = 1'b0;
        chk_d   = 1'b0;
`else
        last_d  = (ra_q == LAST_IDX);
`endif
      end
      S_SEND: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d  = csum_fold(csum_q, data_q);
`endif
          if (ra_q != LAST_IDX) begin
            ra_d = ra_q + 5'd1;
          end else begin
`ifndef REGDUMP_CHECKSUM_EN
            busy_d = 1'b0;
            done_d = 1'b1;
`endif
          end
        end else begin
          valid_d = valid_q;
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      // First CHK cycle loads the checksum beat, later cycles wait for the handshake
      S_CHK: begin
        if (!valid_q) begin
          data_d  = csum_q;
          idx_d   = 5'd0;
          chk_d   = 1'b1;
          last_d  = 1'b1;
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          chk_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          valid_d = 1'b1;
        end
      end
`endif
      S_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ra_q    <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= 5'd0;
      last_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q  <= '0;
      chk_q   <= 1'b0;
`endif
    end else begin
      ra_q    <= ra_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q  <= csum_d;
      chk_q   <= chk_d;
`endif
    end
  end

  assign ra        = ra_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
`ifdef REGDUMP_CHECKSUM_EN
  assign out_chk   = chk_q;
`else
  assign out_chk   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: full dump, backpressure, single-register range,
// ignored start, mid-dump reset and live register update.
module tb_regfile_dumper;
  localparam int DW = 64;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, out_ready;
  logic          busy, done, out_valid, out_last, out_chk;
  logic [4:0]    ra, out_idx;
  logic [DW-1:0] rd, out_data;

  logic          start5, out_ready5;
  logic          busy5, done5, out_valid5, out_last5, out_chk5;
  logic [4:0]    ra5, out_idx5;
  logic [DW-1:0] rd5, out_data5;

  logic [DW-1:0] regs [32];
  assign rd  = regs[ra];
  assign rd5 = regs[ra5];

  regfile_dumper dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .out_chk(out_chk)
  );

  regfile_dumper #(.DW(64), .FIRST_REG(5), .LAST_REG(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .busy(busy5), .done(done5),
    .ra(ra5), .rd(rd5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_data(out_data5), .out_idx(out_idx5), .out_last(out_last5), .out_chk(out_chk5)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int dk;

  logic [63:0] q_data [$];
  logic [4:0]  q_idx  [$];
  logic        q_last [$];
  logic        q_chk  [$];
  int          done_cnt = 0;

  // Beat and done monitor for the default-range instance
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      q_data.push_back(out_data);
      q_idx.push_back(out_idx);
      q_last.push_back(out_last);
      q_chk.push_back(out_chk);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_mon();
    q_data.delete(); q_idx.delete(); q_last.delete(); q_chk.delete();
    done_cnt = 0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic check_stream(input logic [63:0] x4);
    logic [63:0] x;
    logic [63:0] e;
    x = 64'd0;
    chk("beat_count", q_data.size(), 64'(31 + CK));
    for (int i = 0; i < q_data.size(); i++) begin
      if (i < 31) begin
        e = (i == 4) ? x4 : 64'(i);
        x = x ^ e;
        chk("beat_idx", q_idx[i], 64'(i));
        chk("beat_data", q_data[i], e);
        chk("beat_last", q_last[i], 64'((i == 30) && (CK == 0)));
        chk("beat_chk", q_chk[i], 64'd0);
      end else begin
        chk("csum_data", q_data[i], x);
        chk("csum_idx", q_idx[i], 64'd0);
        chk("csum_flag", q_chk[i], 64'd1);
        chk("csum_last", q_last[i], 64'd1);
      end
    end
    chk("done_once", done_cnt, 64'd1);
  endtask

  task automatic run(input int mode, output int dkk);
    bit fired;
    bit abort;
    fired = 1'b0;
    abort = 1'b0;
    dkk = -1;
    for (int n = 0; n < 600 && dkk < 0 && !abort; n++) begin
      start = 1'b0;
      if (mode == 1 && !fired && out_valid && out_idx == 5'd7) begin
        fired = 1'b1;
        out_ready = 1'b0;
        repeat (5) begin
          tick();
          chk("bp_valid", out_valid, 64'd1);
          chk("bp_data", out_data, 64'd7);
          chk("bp_idx", out_idx, 64'd7);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_accept", out_valid, 64'd0);
        tick();
        chk("bp_next_valid", out_valid, 64'd1);
        chk("bp_next_idx", out_idx, 64'd8);
      end else if (mode == 2 && !fired && out_valid && out_idx == 5'd3) begin
        fired = 1'b1;
        start = 1'b1;
        regs[4] = 64'h1234;
      end else if (mode == 3 && !fired && out_valid && out_idx == 5'd10) begin
        fired = 1'b1;
        abort = 1'b1;
        reset_n = 1'b0;
        tick();
        chk("rst_valid", out_valid, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_ra", ra, 64'd0);
        chk("rst_done", done, 64'd0);
        reset_n = 1'b1;
      end
      if (!abort) begin
        tick();
        if (done) dkk = cyc - start_cyc;
      end
    end
    start = 1'b0;
    if (mode != 3) chk("done_seen", 64'(dkk >= 0), 64'd1);
    else           chk("reset_hit", 64'(abort), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'(i);
    regs[31] = 64'd0;
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    start5 = 1'b0; out_ready5 = 1'b1;
    tick(); tick();
    chk("reset_busy", busy, 64'd0);
    chk("reset_done", done, 64'd0);
    chk("reset_valid", out_valid, 64'd0);
    chk("reset_last", out_last, 64'd0);
    chk("reset_chk", out_chk, 64'd0);
    chk("reset_data", out_data, 64'd0);
    chk("reset_idx", out_idx, 64'd0);
    chk("reset_ra", ra, 64'd0);
    reset_n = 1'b1;
    tick();

    // Full dump, no backpressure, with latency and done timing
    clear_mon();
    start_pulse();
    chk("lat_busy", busy, 64'd1);
    chk("lat_valid0", out_valid, 64'd0);
    chk("lat_ra", ra, 64'd0);
    tick();
    chk("lat_valid1", out_valid, 64'd1);
    chk("lat_idx", out_idx, 64'd0);
    run(0, dk);
    chk("done_cycle", dk, 64'(62 + 2 * CK));
    chk("done_busy", busy, 64'd0);
    tick(); tick();
    check_stream(64'd4);

    // Backpressure on index 7
    clear_mon();
    start_pulse();
    run(1, dk);
    tick(); tick();
    check_stream(64'd4);

    // Start while busy plus a live write to X4 ahead of its read
    clear_mon();
    start_pulse();
    run(2, dk);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_busy", busy, 64'd0);
    tick();
    chk("start_in_done_idle", busy, 64'd0);
    chk("start_in_done_valid", out_valid, 64'd0);
    check_stream(64'h1234);
    regs[4] = 64'd4;

    // Reset in the middle of a dump, then a fresh dump
    clear_mon();
    start_pulse();
    run(3, dk);
    repeat (6) tick();
    chk("rst_no_done", done_cnt, 64'd0);
    chk("rst_idle", busy, 64'd0);
    clear_mon();
    start_pulse();
    tick();
    chk("fresh_valid", out_valid, 64'd1);
    chk("fresh_idx", out_idx, 64'd0);
    run(0, dk);
    tick(); tick();
    check_stream(64'd4);

    // Single-register range on the second instance
    regs[5] = 64'hDEADBEEF_00000005;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    chk("one_busy", busy5, 64'd1);
    tick();
    chk("one_valid", out_valid5, 64'd1);
    chk("one_idx", out_idx5, 64'd5);
    chk("one_data", out_data5, 64'hDEADBEEF_00000005);
    chk("one_last", out_last5, 64'(CK == 0));
    chk("one_chkflag", out_chk5, 64'd0);
    tick();
`ifdef REGDUMP_CHECKSUM_EN
    chk("one_gap_valid", out_valid5, 64'd0);
    chk("one_gap_busy", busy5, 64'd1);
    tick();
    chk("one_csum_valid", out_valid5, 64'd1);
    chk("one_csum_data", out_data5, 64'hDEADBEEF_00000005);
    chk("one_csum_flag", out_chk5, 64'd1);
    chk("one_csum_last", out_last5, 64'd1);
    chk("one_csum_idx", out_idx5, 64'd0);
    tick();
`endif
    chk("one_done", done5, 64'd1);
    chk("one_done_busy", busy5, 64'd0);
    chk("one_done_valid", out_valid5, 64'd0);
    tick();
    chk("one_done_pulse", done5, 64'd0);
    regs[5] = 64'd5;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Debug readout engine for the 64-bit, 32-entry processor register file. On a start pulse it drives one register-file read port, walks a configurable index range and streams each 64-bit value out over a valid/ready interface, tagged with its register index. It sits beside the datapath on a spare read port and feeds the debug/trace link. It is the reader side of the register file, which remains the writer.

## Interface
- DW, 64: data width; must equal the register-file word width.
- FIRST_REG, 0: first register index dumped.
- LAST_REG, 30: last register index dumped. Must satisfy FIRST_REG <= LAST_REG <= 31. The default excludes X31, which always reads zero.
- clk  in  1  single clock, rising-edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a dump. Sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- ra  out  5  read address to the register-file read port.
- rd  in  DW  combinational read data for ra from the register file.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  stream sink ready.
- out_data  out  DW  beat payload.
- out_idx  out  5  register index of the beat.
- out_last  out  1  marks the final beat of a dump.
- out_chk  out  1  marks the checksum beat. Tied to 0 when REGDUMP_CHECKSUM_EN is not defined.

## Operation
- The state machine has five states: IDLE, READ, SEND, CHK, DONE.
- IDLE → READ when start=1. On that edge: ra <= FIRST_REG, busy <= 1, checksum <= 0.
- READ is a single cycle. On the edge leaving READ:
  - out_data <= rd, out_idx <= ra, out_valid <= 1.
  - out_last <= (ra == LAST_REG) when the checksum feature is off.
  - Next state is SEND.
- SEND holds every output stable while out_valid=1 and out_ready=0.
- On the edge where out_valid && out_ready in SEND:
  - out_valid <= 0 and checksum <= checksum ^ out_data.
  - If ra != LAST_REG: ra <= ra + 1, next state READ.
  - Else: next state CHK when the feature is enabled, otherwise DONE.
- CHK (feature enabled only):
  - Presents out_data = accumulated checksum, out_idx = 0, out_chk = 1, out_last = 1, out_valid = 1.
  - Handshake → DONE.
- DONE lasts one cycle with done=1 and busy=0 on exit, then returns to IDLE.
- ra increments only within FIRST_REG..LAST_REG and never wraps. A 5-bit overflow cannot occur because LAST_REG <= 31.
- Register values are sampled individually in their READ cycle. A write to a register that has not yet been read during the dump is visible in the stream. No snapshot is taken.
- start while busy or in DONE is ignored; there is no queueing.
- When out_valid=0, out_data, out_idx and out_last keep their last values. Sinks must qualify them with out_valid.

## Timing
- Reset values apply on any clk edge with reset_n=0: state IDLE; busy, done, out_valid, out_last and out_chk = 0; out_data = 0; out_idx = 0; ra = 0; checksum = 0.
- Reset mid-dump aborts immediately. No done pulse is produced, and the next dump restarts at FIRST_REG.
- Latency from start to first out_valid is 2 cycles (IDLE→READ, READ→SEND).
- Throughput with out_ready held high is one beat per 2 cycles.
- A dump of N registers with no backpressure:
  - Feature off: done is high in cycle 2N+1 after the start edge.
  - Feature on: add 2 cycles.
- out_valid, once asserted, never drops and its payload never changes until the handshake.

## Configuration
- REGDUMP_CHECKSUM_EN
  - Defined: after the last register beat, emit one extra beat carrying the XOR of all dumped values, with out_chk=1 and out_last=1. The last register beat then has out_last=0.
  - Not defined: no CHK state, no checksum register, out_chk tied to 0, and out_last is set on the LAST_REG beat.

## Test plan
- Register file loaded with X_i = i (X31 = 0), defaults, out_ready=1, start pulse:
  - 31 beats with out_idx = out_data = 0..30, out_last only on index 30.
  - With REGDUMP_CHECKSUM_EN, a 32nd beat with out_data = 0x1F, out_chk=1, out_last=1.
  - done occurs exactly once.
- Backpressure: out_ready low for 5 cycles while a beat for index 7 is pending.
  - out_valid, out_data=7 and out_idx=7 stay stable throughout.
  - The beat is accepted on the first ready cycle and index 8 follows 2 cycles later.
- FIRST_REG = LAST_REG = 5, X5 = 0xDEADBEEF_00000005:
  - Single beat with out_idx=5, out_last=1 (feature off).
  - Checksum beat equals the same value (feature on).
- start pulsed again at beat 3 while busy: ignored, beat count unchanged, exactly one done.
- reset_n low for 1 cycle at beat 10:
  - Next edge has out_valid=0, busy=0, ra=0, and there is no done pulse.
  - A fresh start dumps from index 0.
- Write X4 = 0x1234 one cycle before ra reaches 4: the stream carries 0x1234 at out_idx=4.
